// File: rtl/present_iter_ctrl_if.sv
// Request/result bundle for the iterative PRESENT-style block engine.
// valid/ready: a transfer happens on a rising edge where valid & ready are both 1;
// the producer holds valid and its payload stable until that edge.
interface present_iter_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] din;
  logic [19:0] master_key;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        busy;

  modport master (
    output in_valid, mode, din, master_key, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, mode, din, master_key, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/present_iter_ctrl.sv
// Iterative 16-bit PRESENT-style engine: one shared round and one key scheduler,
// seven rounds per block plus a final key whitening, selectable key order.
package present_iter_pkg;
  function automatic logic [3:0] sbox(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
    endcase
    return r;
  endfunction
endpackage

// Key add, nibble S-box layer, then bit permutation i -> 4*i mod 15 (bit 15 fixed).
module cipher_round (
  input  logic [15:0] state_in,
  input  logic [15:0] rk,
  output logic [15:0] state_out
);
  logic [15:0] x;
  logic [15:0] y;

  always_comb begin
    x = state_in ^ rk;
    y = '0;
    state_out = '0;
    for (int n = 0; n < 4; n++) y[n*4 +: 4] = present_iter_pkg::sbox(x[n*4 +: 4]);
    for (int b = 0; b < 15; b++) state_out[(b * 4) % 15] = y[b];
    state_out[15] = y[15];
  end
endmodule

// k(i) is the top 16 bits of the key register after i updates; each update is
// rotate-left by 7, S-box on the top nibble, and XOR of i into the low 3 bits.
module key_scheduler (
  input  logic [19:0]       key,
  output logic [7:0][15:0]  rks
);
  logic [19:0] kr;

  always_comb begin
    kr = key;
    rks = '0;
    rks[0] = key[19:4];
    for (int i = 1; i < 8; i++) begin
      kr = {kr[12:0], kr[19:13]};
      kr[19:16] = present_iter_pkg::sbox(kr[19:16]);
      kr[2:0] = kr[2:0] ^ 3'(i);
      rks[i] = kr[19:4];
    end
  end
endmodule

module present_iter_ctrl (
  input  logic                     clk,
  input  logic                     rst_n,
  present_iter_ctrl_if.slave       bus,
  output logic [1:0]               state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [2:0]      rnd;
  logic [15:0]     state_reg;
  logic [19:0]     key_reg;
  logic            mode_reg;
  logic [7:0][15:0] rks;
  logic [2:0]      rk_idx;
  logic [15:0]     rk;
  logic [15:0]     kf;
  logic [15:0]     round_out;
  logic            accept;
  logic            last_rnd;

  key_scheduler u_keys (.key(key_reg), .rks(rks));

  // Decipher walks the schedule backwards (k7..k1) and whitens with k0.
  assign rk_idx   = mode_reg ? (3'd7 - rnd) : rnd;
  assign rk       = rks[rk_idx];
  assign kf       = mode_reg ? rks[0] : rks[7];
  assign last_rnd = (rnd == 3'd6);

  cipher_round u_round (.state_in(state_reg), .rk(rk), .state_out(round_out));

  assign accept = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_rnd) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd       <= '0;
      state_reg <= '0;
      key_reg   <= '0;
      mode_reg  <= 1'b0;
    end else if (accept) begin
      rnd       <= '0;
      state_reg <= bus.din;
      key_reg   <= bus.master_key;
      mode_reg  <= bus.mode;
    end else if (state == RUN) begin
      state_reg <= last_rnd ? (round_out ^ kf) : round_out;
      rnd       <= last_rnd ? 3'd0 : (rnd + 3'd1);
    end
  end

  // Outputs decode from state and registers only; dout is gated to zero outside DONE.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.dout      = (state == DONE) ? state_reg : 16'h0000;
  assign state_dbg     = state;
endmodule

// File: tb/tb_present_iter_ctrl.sv
// Directed and table-driven checks of present_iter_ctrl against an independent golden model.
module tb_present_iter_ctrl;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_cmp = 0;
  int         n_err = 0;

  present_iter_ctrl_if bus ();

  present_iter_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- golden model ----------------
  localparam logic [63:0] SB = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] m_sbox(input logic [3:0] v);
    return SB[v*4 +: 4];
  endfunction

  function automatic logic [15:0] m_round(input logic [15:0] s, input logic [15:0] k);
    logic [15:0] x, y, p;
    x = s ^ k;
    for (int n = 0; n < 4; n++) y[n*4 +: 4] = m_sbox(x[n*4 +: 4]);
    p = '0;
    for (int b = 0; b < 16; b++) p[(b == 15) ? 15 : (b * 4) % 15] = y[b];
    return p;
  endfunction

  function automatic logic [127:0] m_keys(input logic [19:0] key);
    logic [127:0] ks;
    logic [19:0]  r;
    r = key;
    ks = '0;
    ks[15:0] = key[19:4];
    for (int i = 1; i < 8; i++) begin
      r = {r[12:0], r[19:13]};
      r[19:16] = m_sbox(r[19:16]);
      r[2:0] = r[2:0] ^ 3'(i);
      ks[i*16 +: 16] = r[19:4];
    end
    return ks;
  endfunction

  function automatic logic [15:0] m_cipher(input logic m, input logic [15:0] d, input logic [19:0] key);
    logic [127:0] ks;
    logic [15:0]  s;
    int           idx;
    ks = m_keys(key);
    s = d;
    for (int i = 0; i < 7; i++) begin
      idx = m ? (7 - i) : i;
      s = m_round(s, ks[idx*16 +: 16]);
    end
    return m ? (s ^ ks[15:0]) : (s ^ ks[127:112]);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_block(input logic m, input logic [15:0] d, input logic [19:0] k,
                           input int max_stall, input logic [15:0] exp, input string tag);
    int guard;
    int lat;
    int stall;
    guard = 0;
    while (!bus.in_ready && guard < 30) begin
      step();
      guard++;
    end
    bus.in_valid   = 1'b1;
    bus.mode       = m;
    bus.din        = d;
    bus.master_key = k;
    bus.out_ready  = 1'b0;
    step();
    bus.in_valid   = 1'b0;
    bus.din        = 16'($urandom);
    bus.master_key = 20'($urandom);
    bus.mode       = 1'($urandom);
    check({tag, "_busy"}, bus.busy, 1);
    wait_done(lat);
    check({tag, "_latency"}, lat, 7);
    check({tag, "_dout"}, bus.dout, exp);
    stall = $urandom_range(0, max_stall);
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, "_hold"}, {bus.out_valid, bus.dout}, {1'b1, exp});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {bus.in_ready, bus.out_valid, bus.busy, bus.dout}, {3'b100, 16'h0000});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        mode;
    logic [15:0] din;
    logic [19:0] key;
    int          stall;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] r1;
    logic [15:0] exp5, expb;
    int          lat;
    int          seen;
    logic        m;
    logic [15:0] d;
    logic [19:0] k;

    vecs[0] = '{1'b1, 16'h0000, 20'h00000, 0, 16'h0};
    vecs[1] = '{1'b1, 16'hFFFF, 20'hFFFFF, 2, 16'h0};
    vecs[2] = '{1'b0, 16'h0000, 20'h00000, 0, 16'h0};
    vecs[3] = '{1'b0, 16'h1234, 20'h56789, 3, 16'h0};
    vecs[4] = '{1'b1, 16'h8001, 20'h80001, 1, 16'h0};
    vecs[5] = '{1'b0, 16'hFFFF, 20'hFFFFF, 0, 16'h0};
    for (int i = 0; i < 6; i++) vecs[i].exp = m_cipher(vecs[i].mode, vecs[i].din, vecs[i].key);

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode = 1'b0;
    bus.din = '0;
    bus.master_key = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_async", {bus.in_ready, bus.out_valid, bus.busy, bus.dout}, {3'b100, 16'h0000});
    step();
    step();
    rst_n = 1'b1;
    step();

    // Scenario 1: idle after reset
    check("s1_in_ready", bus.in_ready, 1);
    check("s1_out_valid", bus.out_valid, 0);
    check("s1_busy", bus.busy, 0);
    check("s1_dout", bus.dout, 16'h0000);
    check("s1_state", state_dbg, 2'd0);

    // Table: includes scenario 2 (mode=1, zero block, zero key) as entry 0
    for (int i = 0; i < 6; i++)
      run_block(vecs[i].mode, vecs[i].din, vecs[i].key, vecs[i].stall, vecs[i].exp,
                $sformatf("vec%0d", i));

    // Scenario 4: forward then decipher of the forward result
    r1 = m_cipher(1'b0, 16'hBEEF, 20'hA5A5A);
    run_block(1'b0, 16'hBEEF, 20'hA5A5A, 1, r1, "s4_fwd");
    run_block(1'b1, r1, 20'hA5A5A, 1, m_cipher(1'b1, r1, 20'hA5A5A), "s4_dec");

    // Scenario 5: inputs churn during RUN with in_valid held high
    exp5 = m_cipher(1'b1, 16'h1234, 20'h0F0F0);
    expb = m_cipher(1'b0, 16'hCAFE, 20'h13579);
    bus.in_valid = 1'b1;
    bus.mode = 1'b1;
    bus.din = 16'h1234;
    bus.master_key = 20'h0F0F0;
    step();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      bus.din = 16'($urandom);
      bus.master_key = 20'($urandom);
      bus.mode = 1'($urandom);
      step();
      lat++;
      check("s5_no_accept", bus.in_ready, 0);
    end
    check("s5_latency", lat, 7);
    check("s5_dout", bus.dout, exp5);
    bus.mode = 1'b0;
    bus.din = 16'hCAFE;
    bus.master_key = 20'h13579;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("s5_idle", {bus.in_ready, bus.out_valid, bus.dout}, {2'b10, 16'h0000});
    step();
    check("s5_held_accept", {bus.busy, bus.in_ready}, 2'b10);
    bus.in_valid = 1'b0;
    wait_done(lat);
    check("s5b_latency", lat, 7);
    check("s5b_dout", bus.dout, expb);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Scenario 6: reset at rnd=3 aborts the block; new request right after release
    bus.in_valid = 1'b1;
    bus.mode = 1'b1;
    bus.din = 16'h5A5A;
    bus.master_key = 20'hFFFFF;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("s6_running", state_dbg, 2'd1);
    rst_n = 1'b0;
    #1;
    check("s6_rst_async", {bus.in_ready, bus.out_valid, bus.busy, bus.dout}, {3'b100, 16'h0000});
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.out_valid) seen++;
    end
    m = 1'b1;
    d = 16'h0F1E;
    k = 20'h2468A;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.mode = m;
    bus.din = d;
    bus.master_key = k;
    step();
    bus.in_valid = 1'b0;
    check("s6_first_edge_accept", bus.busy, 1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("s6_no_stale_valid", seen, 0);
    check("s6_latency", lat, 7);
    check("s6_dout", bus.dout, m_cipher(m, d, k));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Scenario 3: random decipher traffic with random consumer stalls
    for (int i = 0; i < 200; i++) begin
      d = 16'($urandom);
      k = 20'($urandom);
      run_block(1'b1, d, k, 3, m_cipher(1'b1, d, k), "s3_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
